// File: rtl/three_bit_seq_multiplier_pkg.sv
// Shared constants and state encoding for the 3-bit shift-add multiplier.
package three_bit_seq_multiplier_pkg;

  // Operand width the adder instance is built for.
  localparam int WIDTH_DEF = 3;

  // Iteration counter width.
  localparam int CNT_W_DEF = 2;

  // Product width.
  localparam int PW = 2 * WIDTH_DEF;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : three_bit_seq_multiplier_pkg

// File: rtl/three_bit_seq_multiplier_adder.sv
// 3-bit ripple-carry adder used as the multiplier's only arithmetic element.
module three_bit_adder (
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic       cin,
  output logic [2:0] sum,
  output logic       cout
);

  logic [3:0] carry;

  // Ripple the carry through one full adder per bit.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 3; i++) begin
      sum[i]       = x[i] ^ y[i] ^ carry[i];
      carry[i + 1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
    end
    cout = carry[3];
  end

endmodule : three_bit_adder

// File: rtl/three_bit_seq_multiplier.sv
// Sequential shift-add multiplier: one product per 4-cycle transaction
// with a start/busy/done handshake.
module three_bit_seq_multiplier
  import three_bit_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    product
);

  // The adder instance is hard-wired to 3 bits, so reject anything else.
  if (WIDTH != 3) begin : g_bad_width
    $error("three_bit_seq_multiplier: WIDTH must be 3");
  end
  if ((2 ** CNT_W) < WIDTH) begin : g_bad_cnt_w
    $error("three_bit_seq_multiplier: CNT_W too narrow for WIDTH");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   p_hi_q, p_hi_d;
  logic [WIDTH-1:0]   p_lo_q, p_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      product_q, product_d;

  logic [WIDTH-1:0]   add_y;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH-1:0]   shift_hi;
  logic [WIDTH-1:0]   shift_lo;

  // Multiplicand gated by the current multiplier bit; a zero bit adds nothing.
  assign add_y = m_q & {WIDTH{p_lo_q[0]}};

  three_bit_adder u_adder (
    .x    (p_hi_q),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // {cout, sum, P_lo} shifted right by one; the carry becomes the new top bit.
  assign shift_hi = {add_cout, add_sum[WIDTH-1:1]};
  assign shift_lo = {add_sum[0], p_lo_q[WIDTH-1:1]};

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          m_d     = a;
          p_lo_d  = b;
          p_hi_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_hi_d = shift_hi;
        p_lo_d = shift_lo;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = {shift_hi, shift_lo};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule : three_bit_seq_multiplier

// File: tb/tb_three_bit_seq_multiplier.sv
// Self-checking bench for the 3-bit sequential multiplier.
module tb_three_bit_seq_multiplier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] a;
  logic [2:0] b;
  logic       busy;
  logic       done;
  logic [5:0] product;

  int checks;
  int failures;
  int done_seen;

  // Transaction-level reference: cycles left in the current operation,
  // the pending result, and the visible outputs.
  int         mdl_left;
  int         mdl_pending;
  logic       mdl_done;
  logic [5:0] mdl_product;
  logic       mdl_ready;

  three_bit_seq_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Generic comparison used by the compare process and the directed checks.
  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one start request for a single cycle.
  task automatic applyStimulus(input logic [2:0] av, input logic [2:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    a     = 3'bx;
    b     = 3'bx;
  endtask

  // Wait (bounded) for done; report how many busy cycles were observed.
  task automatic waitDone(input string name, output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      if (busy === 1'b1) busy_cycles++;
      n++;
      @(negedge clk);
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: done timeout, got done=%0b, expected 1", name, done);
    end
  endtask

  // Reference model: a 3-cycle countdown per accepted start, product = a*b.
  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_left    = 0;
      mdl_done    = 1'b0;
      mdl_product = '0;
      mdl_ready   = 1'b1;
    end else if (mdl_left > 0) begin
      mdl_left = mdl_left - 1;
      mdl_done = (mdl_left == 0);
      if (mdl_left == 0) mdl_product = 6'(mdl_pending);
    end else begin
      mdl_done = 1'b0;
      if (start) begin
        mdl_left    = 3;
        mdl_pending = int'(a) * int'(b);
      end
    end
  end

  // Compare DUT against the model on every falling edge after the first reset.
  always @(negedge clk) begin
    if (mdl_ready) begin
      checkOutput("cyc_busy", {7'd0, busy}, {7'd0, (mdl_left > 0)});
      checkOutput("cyc_done", {7'd0, done}, {7'd0, mdl_done});
      checkOutput("cyc_product", {2'd0, product}, {2'd0, mdl_product});
    end
    if (done === 1'b1) done_seen++;
  end

  initial begin
    int bc;
    int d0;
    checks    = 0;
    failures  = 0;
    done_seen = 0;
    mdl_ready = 1'b0;
    mdl_left  = 0;
    mdl_done  = 1'b0;
    mdl_product = '0;
    mdl_pending = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset held two cycles, then idle with start low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_done", {7'd0, done}, 8'd0);
    checkOutput("rst_product", {2'd0, product}, 8'd0);
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", {7'd0, busy}, 8'd0);
    checkOutput("idle_product", {2'd0, product}, 8'd0);

    // 7*7: three busy cycles then done with 49.
    applyStimulus(3'd7, 3'd7);
    waitDone("max", bc);
    checkOutput("max_busy_cycles", 8'(bc), 8'd3);
    checkOutput("max_product", {2'd0, product}, 8'd49);

    // 0*6 still takes full latency, then 5*3.
    applyStimulus(3'd0, 3'd6);
    waitDone("zero", bc);
    checkOutput("zero_busy_cycles", 8'(bc), 8'd3);
    checkOutput("zero_product", {2'd0, product}, 8'd0);
    applyStimulus(3'd5, 3'd3);
    waitDone("mixed", bc);
    checkOutput("mixed_product", {2'd0, product}, 8'd15);

    // Back-to-back: new start accepted in the DONE cycle.
    applyStimulus(3'd4, 3'd1);
    waitDone("b2b_first", bc);
    checkOutput("b2b_first_product", {2'd0, product}, 8'd4);
    start = 1'b1;
    a     = 3'd6;
    b     = 3'd5;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_no_gap_busy", {7'd0, busy}, 8'd1);
    waitDone("b2b_second", bc);
    checkOutput("b2b_second_product", {2'd0, product}, 8'd30);

    // Start during RUN is ignored.
    @(negedge clk);
    d0 = done_seen;
    applyStimulus(3'd3, 3'd2);
    start = 1'b1;
    a     = 3'd7;
    b     = 3'd7;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignored", bc);
    checkOutput("ignored_product", {2'd0, product}, 8'd6);
    repeat (6) @(negedge clk);
    checkOutput("ignored_done_count", 8'(done_seen - d0), 8'd1);

    // Reset on the second RUN edge aborts with no done.
    applyStimulus(3'd7, 3'd5);
    d0 = done_seen;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {7'd0, busy}, 8'd0);
    checkOutput("abort_product", {2'd0, product}, 8'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_done", 8'(done_seen - d0), 8'd0);
    applyStimulus(3'd2, 3'd3);
    waitDone("after_abort", bc);
    checkOutput("after_abort_product", {2'd0, product}, 8'd6);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_three_bit_seq_multiplier
